// File: rtl/ps2_event_arbiter_if.sv
// rtl/ps2_event_arbiter_if.sv - PS/2 event beat stream (tdata/tvalid/tready).
interface ps2_event_arbiter_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ps2_event_arbiter.sv
// rtl/ps2_event_arbiter.sv - Arbitrates coalesced position and FIFO'd button updates onto one tagged beat stream.
module ps2_event_arbiter #(
  parameter int BTN_DEPTH    = 4,
  parameter int MIN_GAP      = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       pxl_clk,
  input  logic                       reset,
  input  logic [11:0]                mouse_x_pos,
  input  logic [11:0]                mouse_y_pos,
  input  logic                       new_event,
  input  logic [2:0]                 btn_state,
  input  logic                       btn_event,
  ps2_event_arbiter_if.master        m_axis,
  output logic [15:0]                coalesce_cnt,
  output logic                       btn_overflow,
  output logic [$clog2(BTN_DEPTH):0] btn_level
);

  localparam int AW = $clog2(BTN_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(BTN_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [GW-1:0] GAP_INIT   = GW'((MIN_GAP == 0) ? 0 : MIN_GAP - 1);
  localparam logic [3:0]    TAG_POS    = 4'h1;
  localparam logic [3:0]    TAG_BTN    = 4'h2;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   gap_cnt, gap_nx;
  logic            load_en;
  logic [3:0]      seq, seq_nx;
  logic [31:0]     tdata_q;
  logic            pend_v;
  logic [23:0]     pend_d;
  logic [2:0]      fifo_mem [BTN_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [SW-1:0]   starve_cnt;
  logic            fifo_empty, fifo_full, cand, accept;
  logic            btn_grant, pos_grant, push_ok;

  assign fifo_empty = (btn_level == '0);
  assign fifo_full  = (btn_level == FULL_LEVEL);
  assign cand       = !fifo_empty || pend_v;
  assign accept     = (state == HOLD) && m_axis.tready;
  assign seq_nx     = accept ? seq + 4'd1 : seq;

  // Grants use registered state only, so a same-edge push/strobe is not visible yet.
  assign btn_grant = load_en && !fifo_empty && (!pend_v || (starve_cnt < STARVE_MAX));
  assign pos_grant = load_en && pend_v && !btn_grant;
  assign push_ok   = btn_event && (!fifo_full || btn_grant);

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = (state == HOLD);

  always_ff @(posedge pxl_clk) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_nx;
    end
  end

  // The final gap cycle is itself loadable, giving exactly MIN_GAP idle cycles.
  always_comb begin
    state_nx = state;
    gap_nx   = gap_cnt;
    load_en  = 1'b0;
    case (state)
      IDLE: begin
        load_en = 1'b1;
        if (cand) state_nx = HOLD;
      end
      HOLD: begin
        if (m_axis.tready) begin
          if (MIN_GAP == 0) begin
            load_en  = 1'b1;
            state_nx = cand ? HOLD : IDLE;
          end else begin
            state_nx = GAP;
            gap_nx   = GAP_INIT;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          load_en  = 1'b1;
          state_nx = cand ? HOLD : IDLE;
        end else begin
          gap_nx = gap_cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pxl_clk) begin
    if (reset) begin
      tdata_q      <= '0;
      seq          <= '0;
      pend_v       <= 1'b0;
      pend_d       <= '0;
      coalesce_cnt <= '0;
      starve_cnt   <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      btn_level    <= '0;
      btn_overflow <= 1'b0;
    end else begin
      seq <= seq_nx;

      if (btn_grant)
        tdata_q <= {TAG_BTN, seq_nx, 21'b0, fifo_mem[rd_ptr]};
      else if (pos_grant)
        tdata_q <= {TAG_POS, seq_nx, pend_d};

      if (new_event) begin
        pend_d <= {mouse_x_pos, mouse_y_pos};
        pend_v <= 1'b1;
        if (pend_v && !pos_grant && (coalesce_cnt != 16'hFFFF))
          coalesce_cnt <= coalesce_cnt + 16'd1;
      end else if (pos_grant) begin
        pend_v <= 1'b0;
      end

      if (btn_grant && pend_v)
        starve_cnt <= starve_cnt + 1'b1;
      else if (pos_grant || !pend_v)
        starve_cnt <= '0;

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (btn_grant) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, btn_grant})
        2'b10:   btn_level <= btn_level + 1'b1;
        2'b01:   btn_level <= btn_level - 1'b1;
        default: btn_level <= btn_level;
      endcase
      if (btn_event && !push_ok) btn_overflow <= 1'b1;
    end
  end

  always_ff @(posedge pxl_clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= btn_state;
  end

endmodule
